// File: rtl/als_spi_responder.sv
// -----------------------------------------------------------------------------
// als_spi_responder
//   Peripheral-side responder for the processor control register. When START
//   (ctrl_in[0]) is seen in IDLE it acknowledges (clears DONE), clocks one
//   16-bit SPI frame out of the ambient-light-sensor ADC (CPOL=1, MSB first,
//   sampled on SCLK rising edges), publishes the 8-bit sample plus a frame
//   error flag to the data register, then writes DONE=1/START=0 back.
//
//   Optional build macro ALS_AVG4_EN: every START runs four back-to-back
//   frames and publishes the truncated average of the four samples, with the
//   error flags ORed together.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous reset, active low
//   ctrl_in   control register contents (bit 0 START, bit 1 DONE)
//   wr2_c     one-cycle write strobe to control bits [1:0]
//   in2       value for control bits [1:0] when wr2_c = 1
//   data_out  [7:0] sample, [30:8] zero, [31] frame error
//   data_we   one-cycle write strobe to the data register
//   cs_n      sensor chip select, active low
//   sclk      SPI clock, idles high
//   miso      sensor serial data
// -----------------------------------------------------------------------------
module als_spi_responder #(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ctrl_in,
  output logic        wr2_c,
  output logic [1:0]  in2,
  output logic [31:0] data_out,
  output logic        data_we,
  output logic        cs_n,
  output logic        sclk,
  input  logic        miso
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HOLD = DW'(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_SHIFT,
    S_HOLD,
    S_DONE,
    S_SETTLE,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     sh_q, sh_d;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic            wr2_c_q, wr2_c_d;
  logic [1:0]      in2_q, in2_d;
  logic            data_we_q, data_we_d;
  logic [31:0]     data_out_q, data_out_d;

  // Only START is consumed here.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_in[31:1];

`ifdef ALS_AVG4_EN
  localparam logic [DW-1:0] DIV_GAP = DW'(CLK_DIV - 2);
  logic [1:0] frm_q, frm_d;
  logic [9:0] acc_q, acc_d;
  logic       err_q, err_d;
  logic [9:0] sum10;
  assign sum10 = acc_q + {2'b00, sh_q[12:5]};
`endif

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    wr2_c_d    = 1'b0;
    in2_d      = 2'b00;
    data_we_d  = 1'b0;
    data_out_d = data_out_q;
`ifdef ALS_AVG4_EN
    frm_d      = frm_q;
    acc_d      = acc_q;
    err_d      = err_q;
`endif
    // Outputs are registered, so strobes are raised on the transition into
    // the state that owns them.
    case (state_q)
      S_IDLE: begin
        if (ctrl_in[0]) begin
          state_d = S_ACCEPT;
          wr2_c_d = 1'b1;
          in2_d   = 2'b01;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
`ifdef ALS_AVG4_EN
          frm_d   = '0;
          acc_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      // ACCEPT is the first cycle of the initial SCLK-high half period.
      S_ACCEPT: begin
        state_d = S_SHIFT;
        div_d   = div_q + 1'b1;
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // This edge drives sclk 0->1: capture the bit now.
            sh_d[4'd15 - bit_q] = miso;
            if (bit_q == 4'd15) state_d = S_HOLD;
            else                bit_d   = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      // SCLK stays high; cs_n rises after CLK_DIV cycles and is held one
      // more cycle before the result is written.
      S_HOLD: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) cs_n_d = 1'b1;
        if (div_q == DIV_HOLD) begin
          div_d = '0;
`ifdef ALS_AVG4_EN
          acc_d = sum10;
          err_d = err_q | (|sh_q[15:13]);
          if (frm_q == 2'd3) begin
            state_d    = S_DONE;
            wr2_c_d    = 1'b1;
            in2_d      = 2'b10;
            data_we_d  = 1'b1;
            data_out_d = {err_q | (|sh_q[15:13]), 23'd0, sum10[9:2]};
          end else begin
            frm_d   = frm_q + 2'd1;
            state_d = S_GAP;
          end
`else
          state_d    = S_DONE;
          wr2_c_d    = 1'b1;
          in2_d      = 2'b10;
          data_we_d  = 1'b1;
          data_out_d = {|sh_q[15:13], 23'd0, sh_q[12:5]};
`endif
        end
      end
`ifdef ALS_AVG4_EN
      // cs_n high between frames; together with the last HOLD cycle this
      // gives CLK_DIV cycles of deselect.
      S_GAP: begin
        if (div_q == DIV_GAP) begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          cs_n_d  = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      S_DONE:   state_d = S_SETTLE;
      // The register applies our write one cycle late; wait it out so the
      // START we just cleared is not seen again.
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      sclk_q     <= 1'b1;
      cs_n_q     <= 1'b1;
      wr2_c_q    <= 1'b0;
      in2_q      <= 2'b00;
      data_we_q  <= 1'b0;
      data_out_q <= '0;
`ifdef ALS_AVG4_EN
      frm_q      <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      wr2_c_q    <= wr2_c_d;
      in2_q      <= in2_d;
      data_we_q  <= data_we_d;
      data_out_q <= data_out_d;
`ifdef ALS_AVG4_EN
      frm_q      <= frm_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
`endif
    end
  end

  assign wr2_c    = wr2_c_q;
  assign in2      = in2_q;
  assign data_out = data_out_q;
  assign data_we  = data_we_q;
  assign cs_n     = cs_n_q;
  assign sclk     = sclk_q;

endmodule

// File: tb/tb_als_spi_responder.sv
// Directed bench for als_spi_responder: register model with one-cycle write
// latency, SPI sensor model driving miso on sclk falls, timing/data checks.
module tb_als_spi_responder;
  localparam int D = 25;
`ifdef ALS_AVG4_EN
  localparam int EXTRA = 102 * D;
  localparam int NFR   = 4;
`else
  localparam int EXTRA = 0;
  localparam int NFR   = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ctrl = 32'd0;
  logic        wr2_c, data_we, cs_n, sclk;
  logic [1:0]  in2;
  logic [31:0] data_out;
  logic        miso = 1'b0;

  als_spi_responder #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl), .wr2_c(wr2_c), .in2(in2),
    .data_out(data_out), .data_we(data_we), .cs_n(cs_n), .sclk(sclk),
    .miso(miso)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Control register: peripheral writes land one cycle after the strobe.
  logic       cpu_start = 1'b0;
  logic       wr_p = 1'b0;
  logic [1:0] in2_p = 2'b00;
  always @(posedge clk) begin
    wr_p  <= wr2_c;
    in2_p <= in2;
    if (wr_p) ctrl[1:0] <= in2_p | {1'b0, cpu_start};
    else if (cpu_start) ctrl[0] <= 1'b1;
  end

  // Sensor model and event monitor.
  logic [15:0] frames [16];
  logic [15:0] cur = 16'd0;
  int bidx = 15;
  logic cs_prev = 1'b1, sclk_prev = 1'b1;
  int n_acc = 0, n_done = 0, n_csfall = 0, rise_cnt = 0;
  int acc_cyc = 0, done_cyc = 0, first_fall = 0, last_rise = 0, cs_rise = 0;
  logic [31:0] done_data = 32'd0;
  logic [1:0]  done_in2 = 2'b00;
  logic        done_wr = 1'b0;

  always @(negedge clk) begin
    if (wr2_c && in2 == 2'b01) begin n_acc++; acc_cyc = cyc; first_fall = -1; end
    if (data_we) begin
      n_done++; done_cyc = cyc; done_data = data_out; done_wr = wr2_c; done_in2 = in2;
    end
    if (cs_prev && !cs_n) begin
      cur = frames[n_csfall % 16]; n_csfall++; rise_cnt = 0; bidx = 15;
    end
    if (!cs_prev && cs_n) cs_rise = cyc;
    if (!cs_n && sclk_prev && !sclk) begin
      if (first_fall < 0) first_fall = cyc;
      if (bidx >= 0) begin miso = cur[bidx]; bidx--; end
    end
    if (!cs_n && !sclk_prev && sclk) begin rise_cnt++; last_rise = cyc; end
    cs_prev = cs_n;
    sclk_prev = sclk;
  end

  int n_cmp = 0, n_err = 0;

  task automatic start_txn(output int t);
    @(posedge clk); #1 cpu_start = 1'b1;
    @(posedge clk); #1 cpu_start = 1'b0;
    t = cyc;
  endtask

  task automatic wait_done(input int prev);
    int i = 0;
    while (n_done == prev && i < 6000) begin @(posedge clk); i++; end
    #1;
    n_cmp++;
    if (n_done == prev) begin n_err++; $display("FAIL done_timeout: no data_we within %0d cycles", i); end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (cs_n !== 1'b1)      begin n_err++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
    n_cmp++; if (sclk !== 1'b1)      begin n_err++; $display("FAIL rst_sclk: got %b want 1", sclk); end
    n_cmp++; if (wr2_c !== 1'b0)     begin n_err++; $display("FAIL rst_wr2_c: got %b want 0", wr2_c); end
    n_cmp++; if (in2 !== 2'b00)      begin n_err++; $display("FAIL rst_in2: got %b want 00", in2); end
    n_cmp++; if (data_we !== 1'b0)   begin n_err++; $display("FAIL rst_data_we: got %b want 0", data_we); end
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL rst_data_out: got %h want 0", data_out); end
    @(posedge clk); #1 rst = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (cs_n !== 1'b1)      begin n_err++; $display("FAIL idle_cs_n: got %b want 1", cs_n); end
    n_cmp++; if (sclk !== 1'b1)      begin n_err++; $display("FAIL idle_sclk: got %b want 1", sclk); end
    n_cmp++; if (n_acc + n_done != 0) begin n_err++; $display("FAIL idle_strobes: got %0d want 0", n_acc + n_done); end
    n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL idle_data_out: got %h want 0", data_out); end
  endtask

  task automatic test_frame(input logic [15:0] fr, input logic [31:0] exp);
    int t, pa, pd;
    for (int k = 0; k < NFR; k++) frames[(n_csfall + k) % 16] = fr;
    pa = n_acc; pd = n_done;
    start_txn(t);
    wait_done(pd);
    n_cmp++; if (acc_cyc != t + 1)           begin n_err++; $display("FAIL accept_cyc: got %0d want %0d", acc_cyc, t + 1); end
    n_cmp++; if (first_fall != t + 1 + D)    begin n_err++; $display("FAIL first_fall: got %0d want %0d", first_fall, t + 1 + D); end
    n_cmp++; if (rise_cnt != 16)             begin n_err++; $display("FAIL rise_cnt: got %0d want 16", rise_cnt); end
    n_cmp++; if (last_rise != t + 1 + 32*D + EXTRA) begin n_err++; $display("FAIL last_rise: got %0d want %0d", last_rise, t + 1 + 32*D + EXTRA); end
    n_cmp++; if (cs_rise != t + 1 + 33*D + EXTRA)   begin n_err++; $display("FAIL cs_rise: got %0d want %0d", cs_rise, t + 1 + 33*D + EXTRA); end
    n_cmp++; if (done_cyc != t + 2 + 33*D + EXTRA)  begin n_err++; $display("FAIL done_cyc: got %0d want %0d", done_cyc, t + 2 + 33*D + EXTRA); end
    n_cmp++; if (done_data !== exp)          begin n_err++; $display("FAIL data_out: got %h want %h", done_data, exp); end
    n_cmp++; if ({done_wr, done_in2} !== 3'b110) begin n_err++; $display("FAIL done_wr2: got %b want 110", {done_wr, done_in2}); end
    repeat (60) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ctrl[1:0] !== 2'b10)        begin n_err++; $display("FAIL ctrl_after: got %b want 10", ctrl[1:0]); end
    n_cmp++; if (n_acc != pa + 1)            begin n_err++; $display("FAIL accept_count: got %0d want %0d", n_acc - pa, 1); end
    n_cmp++; if (data_out !== exp)           begin n_err++; $display("FAIL data_hold: got %h want %h", data_out, exp); end
  endtask

  task automatic test_rst_mid;
    int t, pa, pd, i;
    frames[n_csfall % 16] = 16'hFFE0;
    for (int k = 1; k <= NFR; k++) frames[(n_csfall + k) % 16] = 16'h0B40;
    pa = n_acc; pd = n_done;
    start_txn(t);
    i = 0;
    while (rise_cnt != 7 && i < 3000) begin @(posedge clk); i++; end
    n_cmp++; if (rise_cnt != 7) begin n_err++; $display("FAIL bit7_timeout: got %0d rises want 7", rise_cnt); end
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({cs_n, sclk} !== 2'b11) begin n_err++; $display("FAIL abort_lines: got %b want 11", {cs_n, sclk}); end
    #1 rst = 1'b1;
    wait_done(pd);
    repeat (60) @(posedge clk);
    #1;
    n_cmp++; if (n_done != pd + 1)       begin n_err++; $display("FAIL abort_done_count: got %0d want %0d", n_done - pd, 1); end
    n_cmp++; if (n_acc != pa + 2)        begin n_err++; $display("FAIL abort_acc_count: got %0d want %0d", n_acc - pa, 2); end
    n_cmp++; if (done_data !== 32'h0000005A) begin n_err++; $display("FAIL abort_data: got %h want 0000005a", done_data); end
  endtask

`ifdef ALS_AVG4_EN
  task automatic test_avg4;
    int t, pd, pc;
    frames[(n_csfall + 0) % 16] = 16'h0140;  // 10
    frames[(n_csfall + 1) % 16] = 16'h0280;  // 20
    frames[(n_csfall + 2) % 16] = 16'h03C0;  // 30
    frames[(n_csfall + 3) % 16] = 16'h0520;  // 41
    pd = n_done; pc = n_csfall;
    start_txn(t);
    wait_done(pd);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (done_data !== 32'h00000019) begin n_err++; $display("FAIL avg_data: got %h want 00000019", done_data); end
    n_cmp++; if (n_done != pd + 1)  begin n_err++; $display("FAIL avg_done_count: got %0d want 1", n_done - pd); end
    n_cmp++; if (n_csfall != pc + 4) begin n_err++; $display("FAIL avg_cs_windows: got %0d want 4", n_csfall - pc); end
    n_cmp++; if (done_cyc != t + 2 + 135*D) begin n_err++; $display("FAIL avg_done_cyc: got %0d want %0d", done_cyc, t + 2 + 135*D); end
  endtask
`endif

  initial begin
    for (int k = 0; k < 16; k++) frames[k] = 16'h0000;
    test_reset;
    test_frame(16'h0B40, 32'h0000005A);
    test_frame(16'hFFE0, 32'h800000FF);
    test_rst_mid;
`ifdef ALS_AVG4_EN
    test_avg4;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/als_spi_responder.md
# als_spi_responder

Peripheral-side responder of the processor control register. Watches the register's START bit (bit 0), runs one SPI read of the ambient-light-sensor ADC (16-bit frame, 8-bit sample), and publishes the sample to the data register. Writes status back through the register's peripheral write port (`wr2_c`/`in2`, bits [1:0]): DONE (bit 1) is cleared at acceptance, and DONE is set with START cleared at completion.

## Interface
- `CLK_DIV`, 25: clk cycles per SCLK half-period (50 MHz clk gives 1 MHz SCLK); legal range ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ctrl_in`  in  32  current control register contents; bit 0 = START, bit 1 = DONE.
- `wr2_c`  out  1  one-cycle write strobe to control bits [1:0].
- `in2`  out  2  value written to control bits [1:0] when `wr2_c` = 1.
- `data_out`  out  32  published result: [7:0] sample, [30:8] = 0, [31] = frame error.
- `data_we`  out  1  one-cycle write strobe to the data register.
- `cs_n`  out  1  sensor chip select, active low.
- `sclk`  out  1  SPI clock, idles high (CPOL = 1).
- `miso`  in  1  sensor serial data, MSB first.

## Operation
- Reset values (rst = 0 at a clk edge):
  - `cs_n` = 1, `sclk` = 1.
  - `wr2_c` = 0, `in2` = 0, `data_we` = 0, `data_out` = 0.
  - State = IDLE; bit counter and divider = 0.
- State machine IDLE → ACCEPT → SHIFT → HOLD → DONE → SETTLE → IDLE:
  - IDLE: if `ctrl_in[0]` = 1, go to ACCEPT.
  - ACCEPT (1 cycle): `wr2_c` = 1, `in2` = 2'b01 (keep START, clear DONE). `cs_n` falls.
  - SHIFT: 16 SCLK periods, each low for `CLK_DIV` cycles then high for `CLK_DIV` cycles.
    - `miso` is sampled on each clk where `sclk` goes 0→1.
    - Shift register fills from bit 15 down to bit 0.
  - HOLD: after the 16th rising edge, `sclk` stays high and `cs_n` stays low for `CLK_DIV` cycles, then `cs_n` rises.
  - DONE (1 cycle):
    - `data_we` = 1, `data_out[7:0]` = frame[12:5], `data_out[31]` = |frame[15:13].
    - `wr2_c` = 1, `in2` = 2'b10 (clear START, set DONE).
  - SETTLE (1 cycle): absorbs the register's 1-cycle write latency so a stale START is not re-accepted.
- `data_out` holds its value between transactions. Trailing frame bits [4:0] are ignored.
- START going low mid-transaction: ignored; the transaction completes.
- Processor write in the same cycle as `wr2_c`: the register ORs in1[1:0] with `in2`. This is accepted behaviour and is not arbitrated here.
- `rst` low mid-transaction: the transaction is aborted immediately, with no DONE write and no `data_we`. If START is still set after reset, a fresh transaction starts from IDLE.

## Timing
- Let T = the IDLE cycle in which `ctrl_in[0]` = 1 is seen.
- T+1: ACCEPT strobe; `cs_n` = 0.
- First `sclk` fall: T+1+`CLK_DIV`.
- Rising edge for bit k (k = 0..15): T+1+`CLK_DIV`·(2k+2); the last is at T+1+32·`CLK_DIV`.
- `cs_n` = 1: T+1+33·`CLK_DIV`.
- DONE strobes: T+2+33·`CLK_DIV` (T+827 at default).
- IDLE again: T+4+33·`CLK_DIV`. This is the earliest cycle a new START is accepted.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `ALS_AVG4_EN` defined:
  - Each START runs 4 back-to-back frames, with `cs_n` high for `CLK_DIV` cycles between frames.
  - `data_out[7:0]` = (sum of the four 8-bit samples, 10-bit) >> 2, truncating.
  - `data_out[31]` = OR of the four frame-error flags.
  - ACCEPT/DONE strobes occur once per START.
  - DONE at T+2+33·`CLK_DIV` + 3·34·`CLK_DIV`.
- Not defined: single frame as above; no accumulator logic.

## Test plan
- Reset, then `ctrl_in` = 0 for 100 cycles → `cs_n` = 1, `sclk` = 1, no strobes, `data_out` = 0.
- START set, sensor model returns frame 16'h0B40 (sample 8'h5A) → `wr2_c`/`in2` = 01 at T+1; 16 SCLK periods of 50 cycles; at T+827, `data_we` with `data_out` = 32'h0000005A and `wr2_c`/`in2` = 10.
- Frame 16'hFFE0 → `data_out` = 32'h800000FF (frame error set).
- START held high with the register model applying writes with 1-cycle latency → exactly one transaction per START; no re-accept at SETTLE.
- `rst` low during bit 7 of a frame → `cs_n`/`sclk` high on the next clk, no DONE strobe; with START still 1, a full new transaction follows and completes.
- `ALS_AVG4_EN` with samples 10, 20, 30, 41 → single DONE, `data_out[7:0]` = 25, four `cs_n` low windows.
